// File: rtl/height_pkg.sv
// Shared types and constants for the height history pipeline.
package height_pkg;

   localparam int HIST_DEPTH    = 10;
   localparam int MAX_HEIGHT_IN = 107;

   typedef logic [7:0] height_t;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      WAIT_CLEAR
   } hh_state_t;

   // The display shows at most 8'11", so anything taller is pinned there.
   function automatic height_t clamp_height(input logic [11:0] v);
      return (v > 12'(MAX_HEIGHT_IN)) ? height_t'(MAX_HEIGHT_IN) : v[7:0];
   endfunction

endpackage

// File: rtl/height_shift_reg.sv
// History store: newest value enters at index 0, oldest falls off the top.
module height_shift_reg
   import height_pkg::*;
#(
   parameter int DEPTH = HIST_DEPTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  shift_en,
   input  logic                  clear,
   input  height_t               din,
   output height_t [DEPTH-1:0]   hist
);

   height_t [DEPTH-1:0] r_hist;

   always_ff @(posedge clk) begin
      if (!reset_n)
         r_hist <= '0;
      else if (clear)
         r_hist <= '0;
      else if (shift_en)
         r_hist <= {r_hist[DEPTH-2:0], din};
   end

   assign hist = r_hist;

endmodule

// File: rtl/height_history.sv
// Distance-to-height conversion, stillness detection and one commit per visit.
// Optional feature macro: HEIGHT_HISTORY_AVG_EN (commit the mean of the stable run).
module height_history
   import height_pkg::*;
#(
   parameter int MOUNT_IN      = 96,
   parameter int MIN_HEIGHT_IN = 36,
   parameter int TOL_IN        = 1,
   parameter int STABLE_COUNT  = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       sample_valid,
   input  logic [7:0] distance_in,
   input  logic       clear_hist,
   output logic [7:0] hist_0,
   output logic [7:0] hist_1,
   output logic [7:0] hist_2,
   output logic [7:0] hist_3,
   output logic [7:0] hist_4,
   output logic [7:0] hist_5,
   output logic [7:0] hist_6,
   output logic [7:0] hist_7,
   output logic [7:0] hist_8,
   output logic [7:0] hist_9,
   output logic       new_entry,
   output logic [3:0] entry_count,
   output logic       present
);

   localparam height_t MOUNT_H = height_t'(MOUNT_IN);
   localparam height_t MIN_H   = height_t'(MIN_HEIGHT_IN);
   localparam height_t TOL_H   = height_t'(TOL_IN);

   hh_state_t  r_state, w_state_nxt;
   height_t    r_ref, w_ref_nxt;
   logic [3:0] r_stable_cnt, w_cnt_nxt, w_cnt_inc;
   logic [3:0] r_count;
   logic       r_new_entry;
   logic       w_commit;
   height_t    w_h, w_diff, w_commit_val;
   logic       w_occ, w_in_tol;
   height_t [HIST_DEPTH-1:0] w_hist;

`ifdef HEIGHT_HISTORY_AVG_EN
   localparam int AVG_SHIFT = $clog2(STABLE_COUNT);
   logic [11:0] r_acc, w_acc_nxt;
`endif

   assign w_h      = (distance_in < MOUNT_H) ? (MOUNT_H - distance_in) : '0;
   assign w_occ    = (w_h >= MIN_H);
   assign w_diff   = (w_h >= r_ref) ? (w_h - r_ref) : (r_ref - w_h);
   assign w_in_tol = (w_diff <= TOL_H);
   assign w_cnt_inc = r_stable_cnt + 4'd1;

   always_comb begin
      w_state_nxt = r_state;
      w_ref_nxt   = r_ref;
      w_cnt_nxt   = r_stable_cnt;
      w_commit    = 1'b0;
`ifdef HEIGHT_HISTORY_AVG_EN
      w_acc_nxt   = r_acc;
`endif
      if (sample_valid) begin
         case (r_state)
            IDLE: begin
               if (w_occ) begin
                  w_ref_nxt   = w_h;
                  w_cnt_nxt   = 4'd1;
                  w_state_nxt = SETTLE;
`ifdef HEIGHT_HISTORY_AVG_EN
                  w_acc_nxt   = 12'(w_h);
`endif
               end
            end
            SETTLE: begin
               if (!w_occ) begin
                  w_state_nxt = IDLE;
               end else if (w_in_tol) begin
                  w_ref_nxt = w_h;
                  w_cnt_nxt = w_cnt_inc;
`ifdef HEIGHT_HISTORY_AVG_EN
                  w_acc_nxt = r_acc + 12'(w_h);
`endif
                  if (w_cnt_inc == 4'(STABLE_COUNT)) begin
                     w_commit    = 1'b1;
                     w_state_nxt = WAIT_CLEAR;
                  end
               end else begin
                  // Target moved too much: this sample starts a fresh run.
                  w_ref_nxt = w_h;
                  w_cnt_nxt = 4'd1;
`ifdef HEIGHT_HISTORY_AVG_EN
                  w_acc_nxt = 12'(w_h);
`endif
               end
            end
            WAIT_CLEAR: begin
               if (!w_occ)
                  w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

`ifdef HEIGHT_HISTORY_AVG_EN
   assign w_commit_val = clamp_height(w_acc_nxt >> AVG_SHIFT);
`else
   assign w_commit_val = clamp_height(12'(w_h));
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_ref        <= '0;
         r_stable_cnt <= '0;
         r_count      <= '0;
         r_new_entry  <= 1'b0;
`ifdef HEIGHT_HISTORY_AVG_EN
         r_acc        <= '0;
`endif
      end else if (clear_hist) begin
         r_state      <= IDLE;
         r_ref        <= '0;
         r_stable_cnt <= '0;
         r_count      <= '0;
         r_new_entry  <= 1'b0;
`ifdef HEIGHT_HISTORY_AVG_EN
         r_acc        <= '0;
`endif
      end else begin
         r_state      <= w_state_nxt;
         r_ref        <= w_ref_nxt;
         r_stable_cnt <= w_cnt_nxt;
         r_new_entry  <= w_commit;
`ifdef HEIGHT_HISTORY_AVG_EN
         r_acc        <= w_acc_nxt;
`endif
         if (w_commit && (r_count < 4'(HIST_DEPTH)))
            r_count <= r_count + 4'd1;
      end
   end

   // clear_hist outranks shift_en inside the store, so a dropped sample cannot shift.
   height_shift_reg #(.DEPTH(HIST_DEPTH)) u_hist (
      .clk      (clk),
      .reset_n  (reset_n),
      .shift_en (w_commit),
      .clear    (clear_hist),
      .din      (w_commit_val),
      .hist     (w_hist)
   );

   assign hist_0      = w_hist[0];
   assign hist_1      = w_hist[1];
   assign hist_2      = w_hist[2];
   assign hist_3      = w_hist[3];
   assign hist_4      = w_hist[4];
   assign hist_5      = w_hist[5];
   assign hist_6      = w_hist[6];
   assign hist_7      = w_hist[7];
   assign hist_8      = w_hist[8];
   assign hist_9      = w_hist[9];
   assign new_entry   = r_new_entry;
   assign entry_count = r_count;
   assign present     = (r_state == SETTLE) || (r_state == WAIT_CLEAR);

endmodule

// File: tb/tb_height_history.sv
// Scoreboard bench for height_history: expected commits are queued by the
// stimulus and checked by a monitor whenever new_entry pulses.
module tb_height_history;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       sample_valid = 1'b0;
   logic [7:0] distance_in = '0;
   logic       clear_hist = 1'b0;
   logic [7:0] hist_0, hist_1, hist_2, hist_3, hist_4;
   logic [7:0] hist_5, hist_6, hist_7, hist_8, hist_9;
   logic       new_entry, present;
   logic [3:0] entry_count;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int h0;
      int h1;
      int h9;
      int cnt;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   height_history dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sample_valid (sample_valid),
      .distance_in  (distance_in),
      .clear_hist   (clear_hist),
      .hist_0       (hist_0),
      .hist_1       (hist_1),
      .hist_2       (hist_2),
      .hist_3       (hist_3),
      .hist_4       (hist_4),
      .hist_5       (hist_5),
      .hist_6       (hist_6),
      .hist_7       (hist_7),
      .hist_8       (hist_8),
      .hist_9       (hist_9),
      .new_entry    (new_entry),
      .entry_count  (entry_count),
      .present      (present)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every new_entry pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (reset_n && new_entry) begin
         if (exp_q.size() == 0) begin
            check("unexpected_new_entry", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("commit_hist_0", int'(hist_0), e.h0);
            check("commit_hist_1", int'(hist_1), e.h1);
            check("commit_hist_9", int'(hist_9), e.h9);
            check("commit_entry_count", int'(entry_count), e.cnt);
         end
      end
   end

   task automatic sample(input logic [7:0] d);
      @(negedge clk);
      sample_valid = 1'b1;
      distance_in  = d;
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic samples(input logic [7:0] d, input int n);
      for (int i = 0; i < n; i++) sample(d);
   endtask

   task automatic expect_commit(input int h0, input int h1, input int h9, input int cnt);
      exp_t e;
      e.h0 = h0; e.h1 = h1; e.h9 = h9; e.cnt = cnt;
      exp_q.push_back(e);
   endtask

   task automatic check_empty(input string tag);
      check({tag, "_hist_0"}, int'(hist_0), 0);
      check({tag, "_hist_9"}, int'(hist_9), 0);
      check({tag, "_entry_count"}, int'(entry_count), 0);
      check({tag, "_present"}, int'(present), 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check_empty("reset");
      check("reset_new_entry", int'(new_entry), 0);

      // Basic commit: h=70 after four stable samples.
      samples(8'd26, 3);
      expect_commit(70, 0, 0, 1);
      sample(8'd26);
      check("basic_present", int'(present), 1);
      check("basic_hist_5", int'(hist_5), 0);
      sample(8'd96);
      check("leave_present", int'(present), 0);

      // 70,69,71 restarts at 71 (|71-69|=2); run 71,70,70,70 commits 70 (avg 281>>2=70).
      sample(8'd26); sample(8'd27); sample(8'd25); sample(8'd26); sample(8'd26);
      expect_commit(70, 70, 0, 2);
      sample(8'd26);
      sample(8'd96);

      // 70 then 66 restarts; needs three more 66s to commit.
      sample(8'd26); sample(8'd30); sample(8'd30); sample(8'd30);
      expect_commit(66, 70, 0, 3);
      sample(8'd30);
      sample(8'd96);

      // Twelve identical samples commit once only.
      samples(8'd26, 3);
      expect_commit(70, 66, 0, 4);
      samples(8'd26, 9);
      check("hold_present", int'(present), 1);
      sample(8'd96);
      check("hold_leave_present", int'(present), 0);
      samples(8'd20, 3);
      expect_commit(76, 70, 0, 5);
      sample(8'd20);
      sample(8'd96);

      // Distance beyond the mount height is unoccupied.
      sample(8'd200);
      check("far_present", int'(present), 0);
      check("far_entry_count", int'(entry_count), 5);

      // Distance 0 is the tallest in-range height.
      samples(8'd0, 3);
      expect_commit(96, 76, 0, 6);
      sample(8'd0);
      sample(8'd96);

      // Reset mid-SETTLE abandons the run.
      samples(8'd26, 3);
      check("pre_reset_present", int'(present), 1);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check_empty("midreset");
      sample(8'd26);
      sample(8'd96);
      check("midreset_entry_count", int'(entry_count), 0);

      // Wrap-around: heights 60..70, 60 falls off.
      for (int k = 0; k <= 10; k++) begin
         samples(8'(36 - k), 3);
         expect_commit(60 + k, (k > 0) ? 59 + k : 0, (k >= 9) ? 51 + k : 0,
                       (k + 1 > 10) ? 10 : k + 1);
         sample(8'(36 - k));
         sample(8'd96);
      end
      check("wrap_hist_4", int'(hist_4), 66);

      // Clear wins over a coincident sample, which is dropped.
      samples(8'd26, 2);
      @(negedge clk);
      clear_hist   = 1'b1;
      sample_valid = 1'b1;
      distance_in  = 8'd26;
      @(negedge clk);
      clear_hist   = 1'b0;
      sample_valid = 1'b0;
      check_empty("clear");
      samples(8'd26, 3);
      check("clear_no_early_count", int'(entry_count), 0);
      expect_commit(70, 0, 0, 1);
      sample(8'd26);
      sample(8'd96);

      repeat (5) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
